dm_host_ctrl: RTL and testbench
===============================

Name: dm_host_ctrl

Overview:
- Synthesizable host-side sequencer that drives the CPU `top` the same way a bench does.
- It writes two operands into data memory and holds the CPU in reset for a fixed number of cycles, then releases it.
- It waits for `done` (with a watchdog), reads the result word back and presents it with a valid pulse.
- Sits beside `top` on a board or in a system wrapper; owns the data-memory host port while the CPU is held in reset.

Parameters:
- AW, 8, data-memory address width
- DW, 8, data-memory word width
- OP_A_ADDR, 3, address of operand A
- OP_B_ADDR, 4, address of operand B
- RSLT_ADDR, 5, address of the result word
- RST_CYC, 2, number of cycles cpu_reset is held high after the operands are written (≥1)
- TIMEOUT, 2000, number of RUN-state cycles without done before the watchdog fires

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- op_a  in  DW  operand A; captured on accepted start
- op_b  in  DW  operand B; captured on accepted start
- busy  out  1  high in every state except IDLE
- cpu_reset  out  1  active-high reset to the CPU
- cpu_done  in  1  CPU done flag; level, held by the CPU
- dm_addr  out  AW  data-memory host address
- dm_wr_en  out  1  data-memory host write strobe
- dm_wr_data  out  DW  data-memory host write data
- dm_rd_data  in  DW  data-memory host read data; combinational from dm_addr
- rslt  out  DW  result word
- rslt_valid  out  1  one-cycle pulse when rslt is updated
- timeout_err  out  1  sticky error flag: watchdog expired

Behaviour:
- Reset values (reset low): state=IDLE, cpu_reset=1, busy=0, dm_wr_en=0, dm_addr=0, dm_wr_data=0, rslt=0, rslt_valid=0, timeout_err=0, counters=0.
- While reset is low, the CPU is held in reset.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: cpu_reset=1. On start=1, capture op_a/op_b, clear timeout_err, go to WR_A.
  - WR_A: one cycle; dm_addr=OP_A_ADDR, dm_wr_data=op_a, dm_wr_en=1. Go to WR_B.
  - WR_B: one cycle; same as WR_A with OP_B_ADDR and op_b. Go to HOLD.
  - HOLD: dm_wr_en=0; cpu_reset stays 1 for RST_CYC cycles (counter). Then go to RUN.
  - RUN: cpu_reset=0; the watchdog counter increments every cycle.
    - cpu_done=1 → go to READ, regardless of the counter value.
    - Counter reaches TIMEOUT-1 without done → set timeout_err=1, cpu_reset=1, go to IDLE. rslt is not updated.
  - READ: dm_addr=RSLT_ADDR for one cycle. Go to CAP.
  - CAP: rslt<=dm_rd_data, rslt_valid=1 for exactly one cycle, cpu_reset<=1, go to IDLE.
- Latency, start accepted to rslt_valid: 2 (writes) + RST_CYC + N (CPU run cycles up to and including done) + 2 (READ, CAP).
- start while busy: ignored. No queueing.
- cpu_done already high on the first RUN cycle: treated as done. The CPU is responsible for clearing done on its own reset.
- cpu_done and watchdog expiry in the same cycle: done wins. Go to READ; timeout_err stays 0.
- Asynchronous reset mid-run: everything returns immediately to the reset values. A partial memory write is not retried.
- rslt holds its last value until the next CAP; it is not cleared by a timeout.
- Width rules:
  - The watchdog counter width is $clog2(TIMEOUT+1).
  - Addresses are truncated to AW bits.
  - No arithmetic on data.

Decomposition:
- Shared package `host_pkg`:
  - state enum type `host_state_t` {IDLE, WR_A, WR_B, HOLD, RUN, READ, CAP}
  - default address constants OP_A_ADDR, OP_B_ADDR, RSLT_ADDR
  - default TIMEOUT
- One sub-module, `watchdog_cnt`: parameterized up-counter with clear/enable and a terminal-count output, used for both the HOLD and RUN counts.
- The FSM stays in dm_host_ctrl.

Test Plan:
- Reset low, then high, start=0 → cpu_reset=1, busy=0, rslt_valid=0, dm_wr_en=0 throughout.
- start with op_a=4, op_b=6; model the CPU as asserting done 10 cycles after release and memory[5]=10 → memory[3]=4 and memory[4]=6 written on consecutive cycles. cpu_reset falls 2 cycles later. rslt_valid pulses once with rslt=10, 2 cycles after done. cpu_reset then returns to 1.
- CPU never asserts done, TIMEOUT=20 → timeout_err=1 exactly 20 RUN cycles after release, cpu_reset=1, no rslt_valid, rslt unchanged.
- cpu_done rises on the same cycle the watchdog reaches terminal count → READ path taken, timeout_err=0, rslt_valid=1.
- start pulsed again during RUN with op_a=9 → ignored; memory[3] still 4; a single rslt_valid for the first run.
- Reset dropped low during RUN, then raised → immediate reset values; a fresh start then completes normally.

Source files
------------

// File: rtl/host_pkg.sv
// Shared types and default constants for the data-memory host sequencer.
package host_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    WR_B = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4,
    READ = 3'd5,
    CAP  = 3'd6
  } host_state_t;

  localparam int unsigned DEF_OP_A_ADDR = 3;
  localparam int unsigned DEF_OP_B_ADDR = 4;
  localparam int unsigned DEF_RSLT_ADDR = 5;
  localparam int unsigned DEF_RST_CYC   = 2;
  localparam int unsigned DEF_TIMEOUT   = 2000;

endpackage

// File: rtl/dm_host_ctrl_watchdog_cnt.sv
// Saturating up-counter with synchronous clear/enable and a terminal-count flag.
module watchdog_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TERM  = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == WIDTH'(TERM));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dm_host_ctrl.sv
// Host sequencer: loads two operands into data memory, runs the CPU out of reset,
// waits for done under a watchdog and returns the result word with a valid pulse.
module dm_host_ctrl
  import host_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned OP_A_ADDR = DEF_OP_A_ADDR,
  parameter int unsigned OP_B_ADDR = DEF_OP_B_ADDR,
  parameter int unsigned RSLT_ADDR = DEF_RSLT_ADDR,
  parameter int unsigned RST_CYC   = DEF_RST_CYC,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          busy,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic [AW-1:0] dm_addr,
  output logic          dm_wr_en,
  output logic [DW-1:0] dm_wr_data,
  input  logic [DW-1:0] dm_rd_data,
  output logic [DW-1:0] rslt,
  output logic          rslt_valid,
  output logic          timeout_err
);

  localparam int unsigned HOLD_W = $clog2(RST_CYC + 1);
  localparam int unsigned RUN_W  = $clog2(TIMEOUT + 1);

  host_state_t   state_q, state_d;
  logic [DW-1:0] op_b_q;
  logic          busy_q, cpu_reset_q, dm_wr_en_q, rslt_valid_q, timeout_err_q;
  logic [AW-1:0] dm_addr_q;
  logic [DW-1:0] dm_wr_data_q, rslt_q;

  logic accept, timeout_hit;
  logic hold_tc, run_tc;

  watchdog_cnt #(
    .WIDTH (HOLD_W),
    .TERM  (RST_CYC - 1)
  ) u_hold_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (state_q != HOLD),
    .en_i   (state_q == HOLD),
    .tc_o   (hold_tc)
  );

  watchdog_cnt #(
    .WIDTH (RUN_W),
    .TERM  (TIMEOUT - 1)
  ) u_run_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (state_q != RUN),
    .en_i   (state_q == RUN),
    .tc_o   (run_tc)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = WR_A;
        end
      end
      WR_A: state_d = WR_B;
      WR_B: state_d = HOLD;
      HOLD: if (hold_tc) state_d = RUN;
      RUN: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (cpu_done) begin
          state_d = READ;
        end else if (run_tc) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      READ:    state_d = CAP;
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_b_q        <= '0;
      busy_q        <= 1'b0;
      cpu_reset_q   <= 1'b1;
      dm_wr_en_q    <= 1'b0;
      dm_addr_q     <= '0;
      dm_wr_data_q  <= '0;
      rslt_q        <= '0;
      rslt_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != IDLE);
      cpu_reset_q  <= !((state_d == RUN) || (state_d == READ) || (state_d == CAP));
      dm_wr_en_q   <= (state_d == WR_A) || (state_d == WR_B);
      rslt_valid_q <= (state_d == CAP);

      if (accept) begin
        op_b_q        <= op_b;
        timeout_err_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end

      case (state_d)
        WR_A: begin
          dm_addr_q    <= AW'(OP_A_ADDR);
          dm_wr_data_q <= op_a;
        end
        WR_B: begin
          dm_addr_q    <= AW'(OP_B_ADDR);
          dm_wr_data_q <= op_b_q;
        end
        READ:    dm_addr_q <= AW'(RSLT_ADDR);
        default: dm_addr_q <= '0;
      endcase

      if (state_d == CAP) begin
        rslt_q <= dm_rd_data;
      end
    end
  end

  assign busy        = busy_q;
  assign cpu_reset   = cpu_reset_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wr_en    = dm_wr_en_q;
  assign dm_wr_data  = dm_wr_data_q;
  assign rslt        = rslt_q;
  assign rslt_valid  = rslt_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dm_host_ctrl.sv
// Directed bench for dm_host_ctrl with a behavioural data memory and CPU model.
module tb_dm_host_ctrl;

  localparam int unsigned RST_CYC = 2;
  localparam int unsigned TMO     = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] op_a, op_b;
  logic       busy, cpu_reset;
  logic       cpu_done = 1'b0;
  logic [7:0] dm_addr;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;
  logic [7:0] dm_rd_data;
  logic [7:0] rslt;
  logic       rslt_valid;
  logic       timeout_err;

  logic [7:0] mem [256];
  logic [7:0] rslt_word = 8'd10;
  int         done_at   = 10;
  int         run_cyc   = 0;
  int         rv_count  = 0;
  int         checks    = 0;
  int         failures  = 0;

  dm_host_ctrl #(
    .AW        (8),
    .DW        (8),
    .OP_A_ADDR (3),
    .OP_B_ADDR (4),
    .RSLT_ADDR (5),
    .RST_CYC   (RST_CYC),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .cpu_reset   (cpu_reset),
    .cpu_done    (cpu_done),
    .dm_addr     (dm_addr),
    .dm_wr_en    (dm_wr_en),
    .dm_wr_data  (dm_wr_data),
    .dm_rd_data  (dm_rd_data),
    .rslt        (rslt),
    .rslt_valid  (rslt_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Memory: writes land at the end of the strobe cycle; the result word is bench-controlled.
  always @(negedge clk) if (dm_wr_en) mem[dm_addr] = dm_wr_data;
  assign dm_rd_data = (dm_addr == 8'd5) ? rslt_word : mem[dm_addr];

  // CPU: raises done in its done_at-th cycle out of reset (0 = never), clears on reset.
  always @(negedge clk) begin
    if (cpu_reset) begin
      run_cyc  = 0;
      cpu_done = 1'b0;
    end else begin
      run_cyc++;
      if (done_at != 0 && run_cyc >= done_at) cpu_done = 1'b1;
    end
  end

  always @(posedge clk) if (rslt_valid === 1'b1) rv_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a run and follow it through WR_A, WR_B, HOLD and the first RUN cycle.
  task automatic start_run(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk); start = 1'b0;
    chk("wra_en", dm_wr_en, 1);
    chk("wra_addr", dm_addr, 3);
    chk("wra_data", dm_wr_data, a);
    chk("wra_busy", busy, 1);
    chk("wra_cpurst", cpu_reset, 1);
    chk("wra_terr", timeout_err, 0);
    @(negedge clk);
    chk("wrb_en", dm_wr_en, 1);
    chk("wrb_addr", dm_addr, 4);
    chk("wrb_data", dm_wr_data, b);
    for (int i = 0; i < RST_CYC; i++) begin
      @(negedge clk);
      chk("hold_en", dm_wr_en, 0);
      chk("hold_cpurst", cpu_reset, 1);
    end
    @(negedge clk);
    chk("run1_cpurst", cpu_reset, 0);
    chk("mem_a", mem[3], a);
    chk("mem_b", mem[4], b);
  endtask

  // Follow RUN cycles first..last (done in last), then READ, CAP and the return to IDLE.
  task automatic finish_done(input int first, input int last, input logic [7:0] exp);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      chk("run_cpurst", cpu_reset, 0);
      chk("run_valid", rslt_valid, 0);
    end
    @(negedge clk);
    chk("read_addr", dm_addr, 5);
    chk("read_valid", rslt_valid, 0);
    chk("read_busy", busy, 1);
    @(negedge clk);
    chk("cap_valid", rslt_valid, 1);
    chk("cap_rslt", rslt, exp);
    @(negedge clk);
    chk("idle_valid", rslt_valid, 0);
    chk("idle_cpurst", cpu_reset, 1);
    chk("idle_busy", busy, 0);
    chk("idle_rslt", rslt, exp);
    chk("idle_terr", timeout_err, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpurst", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rslt_valid, 0);
    chk("rst_wren", dm_wr_en, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wr_data, 0);
    chk("rst_rslt", rslt, 0);
    chk("rst_terr", timeout_err, 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle0_cpurst", cpu_reset, 1);
      chk("idle0_busy", busy, 0);
      chk("idle0_wren", dm_wr_en, 0);
    end

    // Normal run with a second start pulsed mid-RUN that must be ignored.
    rslt_word = 8'd10; done_at = 10;
    start_run(8'd4, 8'd6);
    repeat (3) @(negedge clk);
    start = 1'b1; op_a = 8'd9;
    @(negedge clk); start = 1'b0;
    chk("ign_busy", busy, 1);
    chk("ign_wren", dm_wr_en, 0);
    finish_done(6, 10, 8'd10);
    repeat (2) @(negedge clk);
    chk("ign_mem3", mem[3], 4);
    chk("ign_idle", busy, 0);
    chk("rv_count1", rv_count, 1);

    // CPU never finishes: watchdog expires after TMO RUN cycles.
    rslt_word = 8'h55; done_at = 0;
    start_run(8'd1, 8'd2);
    for (int k = 2; k <= TMO; k++) begin
      @(negedge clk);
      chk("to_cpurst", cpu_reset, 0);
      chk("to_terr_lo", timeout_err, 0);
    end
    @(negedge clk);
    chk("to_terr", timeout_err, 1);
    chk("to_cpurst_hi", cpu_reset, 1);
    chk("to_busy", busy, 0);
    chk("to_valid", rslt_valid, 0);
    chk("to_rslt", rslt, 10);
    @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    chk("rv_count_to", rv_count, 1);

    // done arrives in the same cycle the watchdog hits terminal count.
    rslt_word = 8'h5A; done_at = TMO;
    start_run(8'd7, 8'd8);
    finish_done(2, TMO, 8'h5A);
    chk("rv_count2", rv_count, 2);

    // Asynchronous reset in the middle of a run, then a fresh run.
    rslt_word = 8'h33; done_at = 10;
    start_run(8'h11, 8'h22);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_cpurst", cpu_reset, 1);
    chk("mid_busy", busy, 0);
    chk("mid_rslt", rslt, 0);
    chk("mid_addr", dm_addr, 0);
    chk("mid_valid", rslt_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_cpurst", cpu_reset, 1);
    chk("post_busy", busy, 0);
    done_at = 3;
    start_run(8'h21, 8'h43);
    finish_done(2, 3, 8'h33);
    chk("rv_count3", rv_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
